// File: rtl/response_pkg.sv
// Shared constants and FSM encoding for the response framer and its FIFO.
package response_pkg;

  localparam int BYTE_W = 8;
  localparam logic [7:0] IDLE_BYTE = 8'h00;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_CODE = 2'd1,
    SEND_DATA = 2'd2,
    SEND_CSUM = 2'd3
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a write while full is ignored and a read while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr_s;
  logic             do_rd_s;

  // full/empty come from the pre-edge count, so a pop never makes room for a same-edge push
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == {CW{1'b0}});
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_wr_s = wr_en & ~full;
  assign do_rd_s = rd_en & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
    end else begin
      if (do_wr_s) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_rd_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr_s, do_rd_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/response_framer.sv
// Queues {code, payload} responses and streams them byte-wise to UART_TX with
// valid/ready handshaking and an optional trailing XOR checksum byte.
module response_framer
  import response_pkg::*;
#(
  parameter int DATA_BYTES  = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int CHECKSUM_EN = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [7:0]              response_code,
  input  logic [8*DATA_BYTES-1:0] response_data,
  input  logic                    tx_ready,
  output logic                    has_response,
  output logic [7:0]              response,
  output logic                    full,
  output logic                    overflow
);

  localparam int DW    = BYTE_W * DATA_BYTES;
  localparam int FW    = BYTE_W + DW;
  localparam int IDX_W = 2;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DW-1:0]       shift_q, shift_d;
  logic [BYTE_W-1:0]   csum_q, csum_d;
  logic [BYTE_W-1:0]   resp_q, resp_d;
  logic                has_q, has_d;
  logic                overflow_q, overflow_d;

  logic [FW-1:0]       head_s;
  logic                fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]    fifo_count_s;
  logic                accept_s, last_s, eof_s, pop_s;
  logic [BYTE_W-1:0]   next_byte_s;

  sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clock),
    .rst_n   (reset_n),
    .wr_en   (enable),
    .wr_data ({response_code, response_data}),
    .rd_en   (pop_s),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  assign accept_s    = has_q & tx_ready;
  assign last_s      = (idx_q == IDX_W'(DATA_BYTES - 1));
  assign eof_s       = accept_s & (((state_q == SEND_DATA) & last_s & (CHECKSUM_EN == 0))
                                   | (state_q == SEND_CSUM));
  assign pop_s       = ~fifo_empty_s & ((state_q == IDLE) | eof_s);
  assign next_byte_s = shift_q[DW-1 -: BYTE_W];

  assign has_response = has_q;
  assign response     = resp_q;
  assign full         = (fifo_count_s == CNT_W'(FIFO_DEPTH));
  assign overflow     = overflow_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= {IDX_W{1'b0}};
      shift_q    <= {DW{1'b0}};
      csum_q     <= 8'h00;
      resp_q     <= IDLE_BYTE;
      has_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      resp_q     <= resp_d;
      has_q      <= has_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!fifo_empty_s) state_d = SEND_CODE; else state_d = IDLE;
      SEND_CODE: if (accept_s) state_d = SEND_DATA; else state_d = SEND_CODE;
      SEND_DATA: begin
        if (accept_s && last_s) begin
          if (CHECKSUM_EN != 0)  state_d = SEND_CSUM;
          else if (fifo_empty_s) state_d = IDLE;
          else                   state_d = SEND_CODE;
        end else begin
          state_d = SEND_DATA;
        end
      end
      SEND_CSUM: begin
        if (!accept_s)         state_d = SEND_CSUM;
        else if (fifo_empty_s) state_d = IDLE;
        else                   state_d = SEND_CODE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // The checksum register restarts from the code at each pop, so it already
  // covers every byte presented once the last payload byte goes out.
  always_comb begin
    idx_d      = idx_q;
    shift_d    = shift_q;
    csum_d     = csum_q;
    resp_d     = resp_q;
    has_d      = has_q;
    overflow_d = overflow_q | (enable & fifo_full_s);
    if (pop_s) begin
      resp_d  = head_s[FW-1 -: BYTE_W];
      has_d   = 1'b1;
      shift_d = head_s[DW-1:0];
      csum_d  = head_s[FW-1 -: BYTE_W];
      idx_d   = {IDX_W{1'b0}};
    end else if (eof_s) begin
      resp_d = IDLE_BYTE;
      has_d  = 1'b0;
      csum_d = 8'h00;
      idx_d  = {IDX_W{1'b0}};
    end else if (accept_s) begin
      case (state_q)
        SEND_CODE: begin
          resp_d  = next_byte_s;
          shift_d = shift_q << BYTE_W;
          csum_d  = csum_q ^ next_byte_s;
          idx_d   = {IDX_W{1'b0}};
        end
        SEND_DATA: begin
          if (!last_s) begin
            resp_d  = next_byte_s;
            shift_d = shift_q << BYTE_W;
            csum_d  = csum_q ^ next_byte_s;
            idx_d   = idx_q + IDX_W'(1);
          end else begin
            resp_d = csum_q;
          end
        end
        default: resp_d = resp_q;
      endcase
    end else begin
      resp_d = resp_q;
    end
  end

endmodule

// File: tb/tb_response_framer.sv
// Bench: dut_a (1 payload byte, no checksum) and dut_b (2 payload bytes, checksum),
// both depth 4, checked by per-DUT byte scoreboards plus per-test inline checks.
module tb_response_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        en_a = 1'b0, rdy_a = 1'b1;
  logic [7:0]  code_a = 8'h00, data_a = 8'h00;
  logic        has_a, full_a, ovf_a;
  logic [7:0]  resp_a;

  logic        en_b = 1'b0, rdy_b = 1'b1;
  logic [7:0]  code_b = 8'h00;
  logic [15:0] data_b = 16'h0000;
  logic        has_b, full_b, ovf_b;
  logic [7:0]  resp_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  always #5 clk = ~clk;

  response_framer #(.DATA_BYTES(1), .FIFO_DEPTH(4), .CHECKSUM_EN(0)) dut_a (
    .clock(clk), .reset_n(rst_n), .enable(en_a), .response_code(code_a),
    .response_data(data_a), .tx_ready(rdy_a), .has_response(has_a),
    .response(resp_a), .full(full_a), .overflow(ovf_a));

  response_framer #(.DATA_BYTES(2), .FIFO_DEPTH(4), .CHECKSUM_EN(1)) dut_b (
    .clock(clk), .reset_n(rst_n), .enable(en_b), .response_code(code_b),
    .response_data(data_b), .tx_ready(rdy_b), .has_response(has_b),
    .response(resp_b), .full(full_b), .overflow(ovf_b));

  // Scoreboards: every byte the sink accepts must be the next expected byte.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n && has_a && rdy_a) begin
      checks++;
      if (qa.size() == 0) begin
        errors++; $display("FAIL stream_a unexpected byte got %h expected none", resp_a);
      end else begin
        e = qa.pop_front();
        if (resp_a !== e) begin errors++; $display("FAIL stream_a got %h expected %h", resp_a, e); end
      end
    end
    if (rst_n && has_b && rdy_b) begin
      checks++;
      if (qb.size() == 0) begin
        errors++; $display("FAIL stream_b unexpected byte got %h expected none", resp_b);
      end else begin
        e = qb.pop_front();
        if (resp_b !== e) begin errors++; $display("FAIL stream_b got %h expected %h", resp_b, e); end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic enq_a(input logic [7:0] c, input logic [7:0] d);
    en_a = 1'b1; code_a = c; data_a = d;
    qa.push_back(c); qa.push_back(d);
    tick();
    en_a = 1'b0;
  endtask

  task automatic enq_b(input logic [7:0] c, input logic [15:0] d, input bit dropped);
    en_b = 1'b1; code_b = c; data_b = d;
    if (!dropped) begin
      qb.push_back(c); qb.push_back(d[15:8]); qb.push_back(d[7:0]);
      qb.push_back(c ^ d[15:8] ^ d[7:0]);
    end
    tick();
    en_b = 1'b0;
  endtask

  task automatic wait_has_b(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (has_b) return;
    end
    checks++; errors++;
    $display("FAIL %s timeout waiting for has_response got 0 expected 1", name);
  endtask

  task automatic wait_drain_b(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (qb.size() == 0 && !has_b) return;
    end
    checks++; errors++;
    $display("FAIL %s drain timeout got %0d pending expected 0", name, qb.size());
  endtask

  task automatic test_reset();
    checks++;
    if ({has_a, resp_a, full_a, ovf_a} !== 11'd0) begin
      errors++; $display("FAIL reset_a got %b expected 0", {has_a, resp_a, full_a, ovf_a});
    end
    checks++;
    if ({has_b, resp_b, full_b, ovf_b} !== 11'd0) begin
      errors++; $display("FAIL reset_b got %b expected 0", {has_b, resp_b, full_b, ovf_b});
    end
  endtask

  task automatic test_single_byte_payload();
    rdy_a = 1'b1;
    enq_a(8'h03, 8'h1A);
    @(negedge clk); checks++;
    if (has_a !== 1'b0) begin errors++; $display("FAIL latency_early got %b expected 0", has_a); end
    @(negedge clk); checks++;
    if (has_a !== 1'b1 || resp_a !== 8'h03) begin
      errors++; $display("FAIL first_byte got %b/%h expected 1/03", has_a, resp_a);
    end
    @(negedge clk); checks++;
    if (has_a !== 1'b1 || resp_a !== 8'h1A) begin
      errors++; $display("FAIL second_byte got %b/%h expected 1/1a", has_a, resp_a);
    end
    @(negedge clk); checks++;
    if (has_a !== 1'b0 || resp_a !== 8'h00) begin
      errors++; $display("FAIL idle_after_a got %b/%h expected 0/00", has_a, resp_a);
    end
    tick();
  endtask

  task automatic test_checksum();
    logic [7:0] exp [4];
    exp[0] = 8'h01; exp[1] = 8'h12; exp[2] = 8'h34; exp[3] = 8'h27;
    rdy_b = 1'b1;
    enq_b(8'h01, 16'h1234, 1'b0);
    wait_has_b("csum");
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (has_b !== 1'b1 || resp_b !== exp[i]) begin
        errors++; $display("FAIL csum_byte%0d got %b/%h expected 1/%h", i, has_b, resp_b, exp[i]);
      end
    end
    @(negedge clk); checks++;
    if (has_b !== 1'b0 || resp_b !== 8'h00) begin
      errors++; $display("FAIL csum_end got %b/%h expected 0/00", has_b, resp_b);
    end
    tick();
  endtask

  task automatic test_backpressure();
    rdy_b = 1'b0;
    enq_b(8'h01, 16'h1234, 1'b0);
    wait_has_b("bp");
    tick();
    rdy_b = 1'b1;
    tick();
    rdy_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); checks++;
      if (has_b !== 1'b1 || resp_b !== 8'h12) begin
        errors++; $display("FAIL bp_hold%0d got %b/%h expected 1/12", i, has_b, resp_b);
      end
    end
    tick();
    rdy_b = 1'b1;
    @(negedge clk);
    @(negedge clk); checks++;
    if (resp_b !== 8'h34) begin errors++; $display("FAIL bp_resume got %h expected 34", resp_b); end
    wait_drain_b("bp");
    tick();
  endtask

  task automatic test_back_to_back();
    rdy_b = 1'b1;
    enq_b(8'hA1, 16'h5566, 1'b0);
    enq_b(8'hB2, 16'h7788, 1'b0);
    wait_has_b("b2b");
    for (int i = 1; i < 8; i++) begin
      @(negedge clk); checks++;
      if (has_b !== 1'b1) begin errors++; $display("FAIL b2b_bubble%0d got 0 expected 1", i); end
    end
    @(negedge clk); checks++;
    if (has_b !== 1'b0) begin errors++; $display("FAIL b2b_end got 1 expected 0"); end
    tick();
  endtask

  task automatic test_overflow();
    rdy_b = 1'b0;
    checks++;
    if (ovf_b !== 1'b0) begin errors++; $display("FAIL ovf_pre got 1 expected 0"); end
    for (int i = 0; i < 6; i++) enq_b(8'hC0 + 8'(i), 16'h1000 + 16'(i * 16'h0111), i == 5);
    @(negedge clk); checks++;
    if (full_b !== 1'b1 || ovf_b !== 1'b1) begin
      errors++; $display("FAIL ovf_flags got full=%b ovf=%b expected 1/1", full_b, ovf_b);
    end
    checks++;
    if (resp_b !== 8'hC0) begin errors++; $display("FAIL ovf_head got %h expected c0", resp_b); end
    tick();
    rdy_b = 1'b1;
    wait_drain_b("ovf");
    checks++;
    if (full_b !== 1'b0 || ovf_b !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got full=%b ovf=%b expected 0/1", full_b, ovf_b);
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    rdy_b = 1'b0;
    enq_b(8'hD1, 16'hAAAA, 1'b0);
    enq_b(8'hD2, 16'hBBBB, 1'b0);
    enq_b(8'hD3, 16'hCCCC, 1'b0);
    tick();
    rdy_b = 1'b1;
    tick();
    rdy_b = 1'b0;
    rst_n = 1'b0;
    #1; checks++;
    if ({has_b, resp_b, full_b, ovf_b} !== 11'd0) begin
      errors++; $display("FAIL midreset got %b expected 0", {has_b, resp_b, full_b, ovf_b});
    end
    qb.delete();
    tick(); tick();
    rst_n = 1'b1;
    rdy_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); checks++;
      if (has_b !== 1'b0) begin errors++; $display("FAIL post_reset_byte got %h expected none", resp_b); end
    end
  endtask

  initial begin
    #2;
    test_reset();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    test_single_byte_payload();
    test_checksum();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
